// File: rtl/led_sw_pkg.sv
// Shared types and select encodings for the LED 2:1 switch arbiter.
package led_sw_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GRANT_A = 2'b01,
        GRANT_B = 2'b10
    } state_e;

    // Mux select encodings, packed as {sel_a, sel_b}.
    localparam logic [1:0] SEL_A    = 2'b00;
    localparam logic [1:0] SEL_B    = 2'b11;
    localparam logic [1:0] SEL_IDLE = 2'b10;

    // Select pair the mux needs for a given arbiter state.
    function automatic logic [1:0] sel_for(input state_e st);
        logic [1:0] sel;
        sel = SEL_IDLE;
        case (st)
            GRANT_A: sel = SEL_A;
            GRANT_B: sel = SEL_B;
            default: sel = SEL_IDLE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/led_switch_arbiter_if.sv
// Request/data/grant bundle between the LED pattern sources and the arbiter.
interface led_switch_arbiter_if;

    logic req_a;
    logic req_b;
    logic data_a;
    logic data_b;
    logic gnt_a;
    logic gnt_b;
    logic sel_a;
    logic sel_b;
    logic busy;
    logic data_c;

    // Source side: drives requests and pattern bits, observes grants.
    modport master (
        output req_a, req_b, data_a, data_b,
        input  gnt_a, gnt_b, sel_a, sel_b, busy, data_c
    );

    // Arbiter side.
    modport slave (
        input  req_a, req_b, data_a, data_b,
        output gnt_a, gnt_b, sel_a, sel_b, busy, data_c
    );

endinterface

// File: rtl/switch_2to1.sv
// Existing LED 2:1 mux: {sel_a,sel_b} = 00 picks A, 11 picks B, anything else drives 0.
module switch_2to1
    import led_sw_pkg::*;
(
    input  logic data_a_i,
    input  logic data_b_i,
    input  logic sel_a_i,
    input  logic sel_b_i,
    output logic data_o
);

    // Decode the select pair into the chosen source bit.
    always_comb begin
        data_o = 1'b0;
        case ({sel_a_i, sel_b_i})
            SEL_A:   data_o = data_a_i;
            SEL_B:   data_o = data_b_i;
            default: data_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/led_switch_arbiter.sv
// Round-robin two-source arbiter with minimum grant hold for the LED select path.
module led_switch_arbiter
    import led_sw_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned CNT_W       = 8
) (
    input logic                  clk,
    input logic                  rst_n,
    led_switch_arbiter_if.slave  bus
);

    localparam logic [CNT_W-1:0] HoldLast = CNT_W'(HOLD_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_b_q, last_b_d;   // 1: B was granted most recently
    logic             expire;

    logic gnt_a_q, gnt_b_q, busy_q, sel_a_q, sel_b_q, data_c_q;
    logic mux_out;

    assign expire = (cnt_q == HoldLast);

    // Next-state, hold counter and round-robin pointer.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_b_d = last_b_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus.req_a && (!bus.req_b || last_b_q)) begin
                    state_d = GRANT_A;
                end else if (bus.req_b) begin
                    state_d = GRANT_B;
                end
            end
            GRANT_A: begin
                if (!expire) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    // Other side wins at expiry; owner re-enters only if B is quiet.
                    cnt_d = '0;
                    if (bus.req_b) begin
                        state_d = GRANT_B;
                    end else if (bus.req_a) begin
                        state_d = GRANT_A;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            GRANT_B: begin
                if (!expire) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    cnt_d = '0;
                    if (bus.req_a) begin
                        state_d = GRANT_A;
                    end else if (bus.req_b) begin
                        state_d = GRANT_B;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        if (state_d != state_q || (state_q != IDLE && expire)) begin
            if (state_d == GRANT_A) begin
                last_b_d = 1'b0;
            end else if (state_d == GRANT_B) begin
                last_b_d = 1'b1;
            end
        end
    end

    // State, counter and pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            last_b_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_b_q <= last_b_d;
        end
    end

    // Datapath mux steered by the registered select pair.
    switch_2to1 u_mux (
        .data_a_i (bus.data_a),
        .data_b_i (bus.data_b),
        .sel_a_i  (sel_a_q),
        .sel_b_i  (sel_b_q),
        .data_o   (mux_out)
    );

    // Registered output decode of the state plus the LED output flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_a_q  <= 1'b0;
            gnt_b_q  <= 1'b0;
            busy_q   <= 1'b0;
            sel_a_q  <= SEL_IDLE[1];
            sel_b_q  <= SEL_IDLE[0];
            data_c_q <= 1'b0;
        end else begin
            gnt_a_q            <= (state_q == GRANT_A);
            gnt_b_q            <= (state_q == GRANT_B);
            busy_q             <= (state_q == GRANT_A) || (state_q == GRANT_B);
            {sel_a_q, sel_b_q} <= sel_for(state_q);
            data_c_q           <= mux_out;
        end
    end

    assign bus.gnt_a  = gnt_a_q;
    assign bus.gnt_b  = gnt_b_q;
    assign bus.busy   = busy_q;
    assign bus.sel_a  = sel_a_q;
    assign bus.sel_b  = sel_b_q;
    assign bus.data_c = data_c_q;

endmodule

// File: tb/tb_led_switch_arbiter.sv
// Directed bench for led_switch_arbiter: HOLD_CYCLES=4 and HOLD_CYCLES=1 instances.
module tb_led_switch_arbiter;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    led_switch_arbiter_if bus4 ();
    led_switch_arbiter_if bus1 ();

    led_switch_arbiter #(.HOLD_CYCLES(4), .CNT_W(8)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4)
    );

    led_switch_arbiter #(.HOLD_CYCLES(1), .CNT_W(8)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and land on the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step4(input logic ra, input logic rb, input logic da, input logic db);
        bus4.req_a  = ra;
        bus4.req_b  = rb;
        bus4.data_a = da;
        bus4.data_b = db;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] dpat;
        bit         hp_ra [10];
        bit         hp_rb [10];
        bit         hp_ea [10];
        bit         hp_eb [10];
        int         ea;
        int         eb;
        int         ed;
        int         es;

        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        bus4.req_a = 1'b0; bus4.req_b = 1'b0; bus4.data_a = 1'b0; bus4.data_b = 1'b0;
        bus1.req_a = 1'b0; bus1.req_b = 1'b0; bus1.data_a = 1'b0; bus1.data_b = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Reset values.
        check_eq("rst_gnt_a", 8'(bus4.gnt_a), 8'd0);
        check_eq("rst_gnt_b", 8'(bus4.gnt_b), 8'd0);
        check_eq("rst_busy", 8'(bus4.busy), 8'd0);
        check_eq("rst_sel", 8'({bus4.sel_a, bus4.sel_b}), 8'b10);
        check_eq("rst_data_c", 8'(bus4.data_c), 8'd0);

        // Contention from reset: A wins first, then AAAA BBBB ... with no gap.
        rst_n = 1'b1;
        for (int k = 1; k <= 23; k++) begin
            step4(1'b1, 1'b1, 1'b0, 1'b1);
            if (k == 1) begin
                ea = 0; eb = 0;
            end else begin
                eb = ((k - 2) / 4) % 2;
                ea = 1 - eb;
            end
            ed = (k >= 3 && ((k - 3) / 4) % 2 == 1) ? 1 : 0;
            check_eq($sformatf("cont_gnt_a_%0d", k), 8'(bus4.gnt_a), 8'(ea));
            check_eq($sformatf("cont_gnt_b_%0d", k), 8'(bus4.gnt_b), 8'(eb));
            check_eq($sformatf("cont_busy_%0d", k), 8'(bus4.busy), 8'(ea | eb));
            check_eq($sformatf("cont_data_c_%0d", k), 8'(bus4.data_c), 8'(ed));
        end

        // Asynchronous reset while B holds the path and data_c is 1.
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_gnt_b", 8'(bus4.gnt_b), 8'd0);
        check_eq("arst_gnt_a", 8'(bus4.gnt_a), 8'd0);
        check_eq("arst_busy", 8'(bus4.busy), 8'd0);
        check_eq("arst_sel", 8'({bus4.sel_a, bus4.sel_b}), 8'b10);
        check_eq("arst_data_c", 8'(bus4.data_c), 8'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Restart with both requesting: last=B again, so A is granted.
        step4(1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("rel_gnt_a_1", 8'(bus4.gnt_a), 8'd0);
        step4(1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("rel_gnt_a_2", 8'(bus4.gnt_a), 8'd1);
        check_eq("rel_gnt_b_2", 8'(bus4.gnt_b), 8'd0);
        for (int k = 3; k <= 7; k++) begin
            step4(1'b0, 1'b0, 1'b0, 1'b0);
            check_eq($sformatf("rel_gnt_a_%0d", k), 8'(bus4.gnt_a), 8'((k <= 5) ? 1 : 0));
        end

        // Single requester: one-clock pulse on req_a gives a 4-clock grant.
        dpat = 9'b001101100;
        for (int k = 1; k <= 8; k++) begin
            step4((k == 1), 1'b0, dpat[k], ~dpat[k]);
            ea = (k >= 2 && k <= 5) ? 1 : 0;
            es = (ea == 1) ? 0 : 2;
            ed = (k >= 3 && k <= 6) ? int'(dpat[k]) : 0;
            check_eq($sformatf("single_gnt_a_%0d", k), 8'(bus4.gnt_a), 8'(ea));
            check_eq($sformatf("single_gnt_b_%0d", k), 8'(bus4.gnt_b), 8'd0);
            check_eq($sformatf("single_sel_%0d", k), 8'({bus4.sel_a, bus4.sel_b}), 8'(es));
            check_eq($sformatf("single_data_c_%0d", k), 8'(bus4.data_c), 8'(ed));
        end

        // Hold persistence: A drops during the hold, B arrives; B only after expiry.
        hp_ra = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        hp_rb = '{0, 0, 0, 1, 1, 0, 0, 0, 0, 0};
        hp_ea = '{0, 1, 1, 1, 1, 0, 0, 0, 0, 0};
        hp_eb = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 0};
        for (int i = 0; i < 10; i++) begin
            step4(hp_ra[i], hp_rb[i], 1'b0, 1'b0);
            check_eq($sformatf("hold_gnt_a_%0d", i + 1), 8'(bus4.gnt_a), 8'(hp_ea[i]));
            check_eq($sformatf("hold_gnt_b_%0d", i + 1), 8'(bus4.gnt_b), 8'(hp_eb[i]));
        end

        // Re-grant: req_a held 10 clocks; re-entries at 4 and 8 restart the hold,
        // so the grant lasts until the third window ends (12 clocks).
        for (int k = 1; k <= 15; k++) begin
            step4((k <= 10), 1'b0, 1'b0, 1'b0);
            ea = (k >= 2 && k <= 13) ? 1 : 0;
            check_eq($sformatf("regrant_gnt_a_%0d", k), 8'(bus4.gnt_a), 8'(ea));
            check_eq($sformatf("regrant_gnt_b_%0d", k), 8'(bus4.gnt_b), 8'd0);
        end

        // HOLD_CYCLES=1 under constant contention: A, B, A, ... every clock.
        bus1.req_a = 1'b1;
        bus1.req_b = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 1) begin
                ea = 0; eb = 0; es = 2;
            end else if (k % 2 == 0) begin
                ea = 1; eb = 0; es = 0;
            end else begin
                ea = 0; eb = 1; es = 3;
            end
            check_eq($sformatf("h1_gnt_a_%0d", k), 8'(bus1.gnt_a), 8'(ea));
            check_eq($sformatf("h1_gnt_b_%0d", k), 8'(bus1.gnt_b), 8'(eb));
            check_eq($sformatf("h1_sel_%0d", k), 8'({bus1.sel_a, bus1.sel_b}), 8'(es));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
